// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_pkg : shared state codes and time-triple type for the       |
// |                 stopwatch controller.            Revision: 1.0        |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

    localparam int TIME_W = 8;

    typedef struct packed {
        logic [TIME_W-1:0] m;
        logic [TIME_W-1:0] s;
        logic [TIME_W-1:0] ms;
    } time_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_SPLIT  = 3'd3,
        ST_RECALL = 3'd4
    } state_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/lap_ring.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lap_ring : DEPTH-entry ring of lap snapshots with wrapping write      |
// |            pointer, saturating count and combinational read.  Rev 1.0 |
// +----------------------------------------------------------------------+
module lap_ring
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          wr_i,
    input  time_t         wdata_i,
    input  logic [IW-1:0] rd_idx_i,
    output time_t         rd_data_o,
    output logic [CW-1:0] cnt_o,
    output logic [IW-1:0] wr_ptr_o
);

    time_t         mem_q [DEPTH];
    logic [IW-1:0] wr_ptr_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (wr_i) begin
            // DEPTH is a power of two, so the pointer wraps by natural overflow
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + IW'(1);
            if (cnt_q != CW'(DEPTH)) cnt_q <= cnt_q + CW'(1);
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign cnt_o     = cnt_q;
    assign wr_ptr_o  = wr_ptr_q;

endmodule : lap_ring
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_ctrl : run/pause/split/recall sequencer and display source  |
// |                  select for the stopwatch timer.     Revision: 1.0    |
// +----------------------------------------------------------------------+
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter  int LAP_DEPTH  = 4,
    parameter  int HOLD_TICKS = 200,
    localparam int CW         = $clog2(LAP_DEPTH + 1),
    localparam int IW         = $clog2(LAP_DEPTH)
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_ss,
    input  logic              btn_lap,
    input  logic              btn_clr,
    input  logic [TIME_W-1:0] cur_ms,
    input  logic [TIME_W-1:0] cur_s,
    input  logic [TIME_W-1:0] cur_m,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [TIME_W-1:0] disp_ms,
    output logic [TIME_W-1:0] disp_s,
    output logic [TIME_W-1:0] disp_m,
    output logic [2:0]        state,
    output logic [CW-1:0]     lap_cnt,
    output logic [IW-1:0]     lap_idx,
    output logic              hold_led
);

    localparam int            HW          = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] lap_idx_q, lap_idx_d;
    logic [CW-1:0] rstep_q, rstep_d;
    logic          cnt_clr_q;
    time_t         disp_q, disp_d;

    logic          w_ss, w_lap, w_cap, w_clr_acc;
    logic [IW-1:0] w_wr_ptr, w_newest, w_rd_idx;
    logic [CW-1:0] w_lap_cnt;
    time_t         w_cur, w_rd_data;

    // clr outranks ss outranks lap; a masked pulse has no effect at all
    assign w_ss     = btn_ss  & ~btn_clr;
    assign w_lap    = btn_lap & ~btn_ss & ~btn_clr;
    assign w_cur    = {cur_m, cur_s, cur_ms};
    assign w_newest = w_wr_ptr - IW'(1);
    assign w_rd_idx = (state_q == ST_RECALL) ? lap_idx_q : w_newest;

    lap_ring #(
        .DEPTH (LAP_DEPTH),
        .IW    (IW),
        .CW    (CW)
    ) u_lap_ring (
        .clk       (mclk),
        .rst       (rst),
        .clr_i     (w_clr_acc),
        .wr_i      (w_cap),
        .wdata_i   (w_cur),
        .rd_idx_i  (w_rd_idx),
        .rd_data_o (w_rd_data),
        .cnt_o     (w_lap_cnt),
        .wr_ptr_o  (w_wr_ptr)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        lap_idx_d = lap_idx_q;
        rstep_d   = rstep_q;
        w_cap     = 1'b0;
        w_clr_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_clr)   w_clr_acc = 1'b1;
                else if (w_ss) state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (w_ss) begin
                    state_d = ST_PAUSE;
                end else if (w_lap) begin
                    w_cap   = 1'b1;
                    hold_d  = HOLD_RELOAD;
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (w_ss) begin
                    state_d = ST_PAUSE;
                end else if (w_lap) begin
                    w_cap  = 1'b1;
                    hold_d = HOLD_RELOAD;
                end else if (tick) begin
                    if (hold_q == '0) state_d = ST_RUN;
                    else              hold_d  = hold_q - HW'(1);
                end
            end
            ST_PAUSE: begin
                if (btn_clr) begin
                    w_clr_acc = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_ss) begin
                    state_d = ST_RUN;
                end else if (w_lap && (w_lap_cnt != '0)) begin
                    state_d   = ST_RECALL;
                    lap_idx_d = w_newest;
                    rstep_d   = '0;
                end
            end
            ST_RECALL: begin
                if (btn_clr) begin
                    w_clr_acc = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_ss) begin
                    state_d = ST_PAUSE;
                end else if (w_lap) begin
                    // only valid slots are visited; after the oldest, go back to the newest
                    if (rstep_q == w_lap_cnt - CW'(1)) begin
                        lap_idx_d = w_newest;
                        rstep_d   = '0;
                    end else begin
                        lap_idx_d = lap_idx_q - IW'(1);
                        rstep_d   = rstep_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign disp_d = ((state_q == ST_SPLIT) || (state_q == ST_RECALL)) ? w_rd_data : w_cur;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            lap_idx_q <= '0;
            rstep_q   <= '0;
            cnt_clr_q <= 1'b0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            lap_idx_q <= lap_idx_d;
            rstep_q   <= rstep_d;
            cnt_clr_q <= w_clr_acc;
            disp_q    <= disp_d;
        end
    end

    assign state    = state_q;
    assign cnt_en   = (state_q == ST_RUN) || (state_q == ST_SPLIT);
    assign hold_led = (state_q == ST_SPLIT) || (state_q == ST_RECALL);
    assign cnt_clr  = cnt_clr_q;
    assign disp_m   = disp_q.m;
    assign disp_s   = disp_q.s;
    assign disp_ms  = disp_q.ms;
    assign lap_cnt  = w_lap_cnt;
    assign lap_idx  = lap_idx_q;

endmodule : stopwatch_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stopwatch_ctrl : directed self-checking bench for stopwatch_ctrl   |
// |                     (LAP_DEPTH=4, HOLD_TICKS=5).       Revision: 1.0  |
// +----------------------------------------------------------------------+
module tb_stopwatch_ctrl;

    logic       mclk, rst, tick, btn_ss, btn_lap, btn_clr;
    logic [7:0] cur_ms, cur_s, cur_m;
    logic       cnt_en, cnt_clr, hold_led;
    logic [7:0] disp_ms, disp_s, disp_m;
    logic [2:0] state;
    logic [2:0] lap_cnt;
    logic [1:0] lap_idx;

    int nvec = 0;
    int nmis = 0;

    logic [23:0] L1, L2, L3, L4, L5;

    stopwatch_ctrl #(
        .LAP_DEPTH  (4),
        .HOLD_TICKS (5)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .tick     (tick),
        .btn_ss   (btn_ss),
        .btn_lap  (btn_lap),
        .btn_clr  (btn_clr),
        .cur_ms   (cur_ms),
        .cur_s    (cur_s),
        .cur_m    (cur_m),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .disp_ms  (disp_ms),
        .disp_s   (disp_s),
        .disp_m   (disp_m),
        .state    (state),
        .lap_cnt  (lap_cnt),
        .lap_idx  (lap_idx),
        .hold_led (hold_led)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one edge, then drop all single-cycle pulses
    task automatic cyc();
        @(posedge mclk);
        #1;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
        tick    = 1'b0;
    endtask

    task automatic setcur(input logic [23:0] v);
        {cur_m, cur_s, cur_ms} = v;
    endtask

    function automatic logic [31:0] dispv();
        return {8'h00, disp_m, disp_s, disp_ms};
    endfunction

    initial begin
        L1 = {8'd3, 8'd10, 8'd11};
        L2 = {8'd4, 8'd20, 8'd22};
        L3 = {8'd5, 8'd30, 8'd33};
        L4 = {8'd6, 8'd40, 8'd44};
        L5 = {8'd7, 8'd50, 8'd55};
        rst = 1'b1; tick = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
        setcur(24'h0);
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_cnt_en", 32'(cnt_en), 0);
        chk("rst_cnt_clr", 32'(cnt_clr), 0);
        chk("rst_disp", dispv(), 0);
        chk("rst_lap_cnt", 32'(lap_cnt), 0);
        chk("rst_lap_idx", 32'(lap_idx), 0);
        rst = 1'b0;
        cyc();

        // start / stop
        btn_ss = 1'b1; cyc();
        chk("ss_run_state", 32'(state), 1);
        chk("ss_run_cnt_en", 32'(cnt_en), 1);
        btn_ss = 1'b1; cyc();
        chk("ss_pause_state", 32'(state), 2);
        chk("ss_pause_cnt_en", 32'(cnt_en), 0);
        btn_ss = 1'b1; cyc();

        // split freezes the display for HOLD_TICKS ticks
        setcur({8'd1, 8'd23, 8'd45}); cyc();
        btn_lap = 1'b1; cyc();
        chk("split_state", 32'(state), 3);
        chk("split_hold_led", 32'(hold_led), 1);
        chk("split_cnt_en", 32'(cnt_en), 1);
        chk("split_lap_cnt", 32'(lap_cnt), 1);
        setcur({8'd1, 8'd23, 8'd46}); cyc();
        chk("split_disp_frozen", dispv(), {8'd0, 8'd1, 8'd23, 8'd45});
        repeat (4) begin tick = 1'b1; cyc(); end
        chk("split_after_4_ticks", 32'(state), 3);
        tick = 1'b1; cyc();
        chk("split_after_5_ticks", 32'(state), 1);
        chk("split_exit_hold_led", 32'(hold_led), 0);
        setcur({8'd2, 8'd0, 8'd0}); cyc();
        chk("run_disp_track", dispv(), {8'd0, 8'd2, 8'd0, 8'd0});
        setcur({8'd2, 8'd0, 8'd1});
        chk("run_disp_lag", dispv(), {8'd0, 8'd2, 8'd0, 8'd0});
        cyc();
        chk("run_disp_follow", dispv(), {8'd0, 8'd2, 8'd0, 8'd1});

        // ss beats lap in RUN
        btn_ss = 1'b1; btn_lap = 1'b1; cyc();
        chk("ss_lap_state", 32'(state), 2);
        chk("ss_lap_lap_cnt", 32'(lap_cnt), 1);

        // clear ignored in RUN, honoured in PAUSE
        btn_ss = 1'b1; cyc();
        btn_clr = 1'b1; cyc();
        chk("clr_run_state", 32'(state), 1);
        chk("clr_run_cnt_clr", 32'(cnt_clr), 0);
        btn_ss = 1'b1; cyc();
        btn_clr = 1'b1; cyc();
        chk("clr_pause_state", 32'(state), 0);
        chk("clr_pause_cnt_clr", 32'(cnt_clr), 1);
        chk("clr_pause_lap_cnt", 32'(lap_cnt), 0);
        cyc();
        chk("clr_pulse_width", 32'(cnt_clr), 0);

        // recall with no laps stays in PAUSE
        btn_ss = 1'b1; cyc();
        btn_ss = 1'b1; cyc();
        btn_lap = 1'b1; cyc();
        chk("recall_empty", 32'(state), 2);

        // five laps into a four-deep ring, with a tick/lap collision
        btn_ss = 1'b1; cyc();
        setcur(L1); btn_lap = 1'b1; cyc();
        repeat (3) begin tick = 1'b1; cyc(); end
        setcur(L2); tick = 1'b1; btn_lap = 1'b1; cyc();
        chk("tick_lap_lap_cnt", 32'(lap_cnt), 2);
        repeat (4) begin tick = 1'b1; cyc(); end
        chk("tick_lap_reload", 32'(state), 3);
        setcur(L3); btn_lap = 1'b1; cyc();
        setcur(L4); btn_lap = 1'b1; cyc();
        chk("lap4_lap_cnt", 32'(lap_cnt), 4);
        setcur(L5); btn_lap = 1'b1; cyc();
        setcur(24'h0); cyc();
        chk("lap5_disp", dispv(), 32'(L5));
        btn_ss = 1'b1; cyc();
        chk("lap_sat_cnt", 32'(lap_cnt), 4);
        btn_lap = 1'b1; cyc();
        chk("recall_state", 32'(state), 4);
        chk("recall_idx0", 32'(lap_idx), 0);
        chk("recall_hold_led", 32'(hold_led), 1);
        cyc();
        chk("recall_L5", dispv(), 32'(L5));
        btn_lap = 1'b1; cyc(); cyc();
        chk("recall_idx_L4", 32'(lap_idx), 3);
        chk("recall_L4", dispv(), 32'(L4));
        btn_lap = 1'b1; cyc(); cyc();
        chk("recall_L3", dispv(), 32'(L3));
        btn_lap = 1'b1; cyc(); cyc();
        chk("recall_L2", dispv(), 32'(L2));
        btn_lap = 1'b1; cyc(); cyc();
        chk("recall_wrap_idx", 32'(lap_idx), 0);
        chk("recall_wrap_L5", dispv(), 32'(L5));

        // asynchronous reset in the middle of a split
        btn_ss = 1'b1; cyc();
        btn_ss = 1'b1; cyc();
        setcur(L1); btn_lap = 1'b1; cyc();
        chk("pre_rst_split", 32'(state), 3);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 0);
        chk("async_rst_cnt_en", 32'(cnt_en), 0);
        chk("async_rst_hold_led", 32'(hold_led), 0);
        chk("async_rst_disp", dispv(), 0);
        chk("async_rst_lap_cnt", 32'(lap_cnt), 0);
        #2 rst = 1'b0;
        cyc();
        btn_lap = 1'b1; cyc();
        chk("idle_lap_state", 32'(state), 0);
        chk("idle_lap_lap_cnt", 32'(lap_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
`default_nettype wire
